// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, valid/ready load.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
// Register stages of the shift path are built from jk_ff cells wired as D-type.

// jk_ff: JK flip-flop with asynchronous active-high clear.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK behaviour: hold, clear, set, toggle
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             last_bit, accept;
  logic             sout_n, active_n;
`ifdef PISO_PARITY_EN
  logic             par_q, par_n;
`endif

  // The last-bit cycle is the only busy cycle that may accept the next word.
`ifdef PISO_PARITY_EN
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
`endif
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // Next-state, next shift value and the registered-output precursors
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_n = state_q;
    cnt_n   = cnt_q;
    sreg_n  = sreg;
`ifdef PISO_PARITY_EN
    par_n   = par_q;
`endif
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sreg_n  = din;
`ifdef PISO_PARITY_EN
      par_n   = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          sreg_n = {sreg[WIDTH-2:0], 1'b0};
          if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_n = PARITY;
`else
            state_n = IDLE;
`endif
            cnt_n = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
`ifdef PISO_PARITY_EN
        PARITY:  state_n = IDLE;
`endif
        default: state_n = state_q;
      endcase
    end

    active_n = (state_n != IDLE);
    case (state_n)
      SHIFT:   sout_n = sreg_n[WIDTH-1];
`ifdef PISO_PARITY_EN
      PARITY:  sout_n = par_n;
`endif
      default: sout_n = 1'b0;
    endcase
  end

  // Shift register stages: jk_ff cells with J = d, K = ~d behave as D flops
  for (genvar i = 0; i < WIDTH; i++) begin : g_sreg
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (sreg_n[i]),
      .k   (~sreg_n[i]),
      .q   (sreg[i])
    );
  end

`ifdef PISO_PARITY_EN
  // Parity bit captured at load so it never depends on the shifted contents
  jk_ff u_par (
    .clk (clk),
    .rst (rst),
    .j   (par_n),
    .k   (~par_n),
    .q   (par_q)
  );
`endif

  // Control state and registered outputs; reset aborts any frame without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sout    <= 1'b0;
      frame   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sout    <= sout_n;
      frame   <= active_n;
      busy    <= active_n;
      done    <= last_bit;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: three piso_tx instances (WIDTH 2, 4, 8) checked every cycle against
// a queue-based reference serializer, plus literal per-bit expectations on WIDTH 4.
// Honours PISO_PARITY_EN the same way as the design.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int            PAR      = 1;
  localparam logic [9:0]    SEQ_ONE  = 10'b10111;
  localparam logic [9:0]    SEQ_B2B  = 10'b1011101100;
  localparam logic [9:0]    SEQ_BUSY = 10'b10001;
  localparam logic [9:0]    SEQ_RST  = 10'b01010;
`else
  localparam int            PAR      = 0;
  localparam logic [9:0]    SEQ_ONE  = 10'b1011;
  localparam logic [9:0]    SEQ_B2B  = 10'b10110110;
  localparam logic [9:0]    SEQ_BUSY = 10'b1000;
  localparam logic [9:0]    SEQ_RST  = 10'b0101;
`endif
  localparam int L4 = 4 + PAR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din_a [3];
  logic        lv_a  [3];
  logic        ready_a [3];
  logic        sout_a  [3];
  logic        frame_a [3];
  logic        busy_a  [3];
  logic        done_a  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int W = (k == 0) ? 2 : (k == 1) ? 4 : 8;

    piso_tx #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din_a[k][W-1:0]),
      .load_valid (lv_a[k]),
      .load_ready (ready_a[k]),
      .sout       (sout_a[k]),
      .frame      (frame_a[k]),
      .busy       (busy_a[k]),
      .done       (done_a[k])
    );

    // Reference serializer: q holds the bits still to be sent, head = bit on the line now
    bit   q[$];
    logic done_m = 1'b0;
    bit   acc;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        done_m = 1'b0;
      end else begin
        acc    = lv_a[k] && (q.size() <= 1);
        done_m = (q.size() == 1);
        if (q.size() > 0) void'(q.pop_front());
        if (acc) begin
          for (int b = W - 1; b >= 0; b--) q.push_back(din_a[k][b]);
          if (PAR == 1) q.push_back(^din_a[k][W-1:0]);
        end
      end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
      check($sformatf("w%0d_sout", W),  32'(sout_a[k]),  32'((q.size() > 0) ? q[0] : 1'b0));
      check($sformatf("w%0d_frame", W), 32'(frame_a[k]), 32'(q.size() > 0));
      check($sformatf("w%0d_busy", W),  32'(busy_a[k]),  32'(q.size() > 0));
      check($sformatf("w%0d_done", W),  32'(done_a[k]),  32'(done_m));
      check($sformatf("w%0d_ready", W), 32'(ready_a[k]), 32'(q.size() <= 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) lv_a[i] = 1'b0;
    repeat (n) tick();
  endtask

  // Literal per-bit expectations on the WIDTH-4 instance, one frame of n bits
  task automatic expect_bits(input string name, input logic [9:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_sout"},  32'(sout_a[1]),  32'(seq[n-1-i]));
      check({name, "_frame"}, 32'(frame_a[1]), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din_a[i] = '0;
      lv_a[i]  = 1'b0;
    end
    #1;
    check("rst_sout",  32'(sout_a[1]),  32'd0);
    check("rst_frame", 32'(frame_a[1]), 32'd0);
    check("rst_busy",  32'(busy_a[1]),  32'd0);
    check("rst_done",  32'(done_a[1]),  32'd0);
    check("rst_ready", 32'(ready_a[1]), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    idle(2);

    // Single frame 1011
    din_a[1] = 32'hB;
    lv_a[1]  = 1'b1;
    tick();
    lv_a[1]  = 1'b0;
    expect_bits("single", SEQ_ONE, L4);
    @(negedge clk);
    check("single_done",     32'(done_a[1]),  32'd1);
    check("single_end_sout", 32'(sout_a[1]),  32'd0);
    check("single_end_frm",  32'(frame_a[1]), 32'd0);
    idle(3);

    // Back-to-back 1011 then 0110 with load_valid held high
    din_a[1] = 32'hB;
    lv_a[1]  = 1'b1;
    tick();
    din_a[1] = 32'h6;
    for (int i = 0; i < 2 * L4; i++) begin
      @(negedge clk);
      check("b2b_sout",  32'(sout_a[1]),  32'(SEQ_B2B[2*L4-1-i]));
      check("b2b_frame", 32'(frame_a[1]), 32'd1);
      check("b2b_done",  32'(done_a[1]),  32'(i == L4));
      if (i == L4) lv_a[1] = 1'b0;
    end
    @(negedge clk);
    check("b2b_done2", 32'(done_a[1]),  32'd1);
    check("b2b_end",   32'(frame_a[1]), 32'd0);
    idle(3);

    // Busy ignore: 1000 in flight while 1111 is offered
    din_a[1] = 32'h8;
    lv_a[1]  = 1'b1;
    tick();
    din_a[1] = 32'hF;
    for (int i = 0; i < L4; i++) begin
      @(negedge clk);
      check("busy_sout",  32'(sout_a[1]),  32'(SEQ_BUSY[L4-1-i]));
      check("busy_ready", 32'(ready_a[1]), 32'(i == L4 - 1));
    end
    @(negedge clk);
    check("busy_next_sout", 32'(sout_a[1]), 32'd1);
    check("busy_next_done", 32'(done_a[1]), 32'd1);
    lv_a[1] = 1'b0;
    idle(L4 + 3);

    // Mid-frame asynchronous reset during bit 2 of 1111
    din_a[1] = 32'hF;
    lv_a[1]  = 1'b1;
    tick();
    lv_a[1]  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_sout",  32'(sout_a[1]),  32'd0);
    check("mrst_frame", 32'(frame_a[1]), 32'd0);
    check("mrst_busy",  32'(busy_a[1]),  32'd0);
    check("mrst_done",  32'(done_a[1]),  32'd0);
    check("mrst_ready", 32'(ready_a[1]), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < L4 + 2; i++) begin
      @(negedge clk);
      check("mrst_no_done", 32'(done_a[1]), 32'd0);
    end
    tick();
    din_a[1] = 32'h5;
    lv_a[1]  = 1'b1;
    tick();
    lv_a[1]  = 1'b0;
    expect_bits("mrst_new", SEQ_RST, L4);
    idle(3);

    // Random words on all widths, mix of gaps and back-to-back loads
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        lv_a[i]  = ($urandom_range(0, 3) != 0);
        din_a[i] = $urandom;
      end
      tick();
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
